// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM activation-memory sequencer.
package lstm_pkg;

    localparam int ADDR_W    = 12;
    localparam int MEM_DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    // Tags that travel with each drained word
    typedef struct packed {
        logic last_step;
        logic last_unit;
    } rd_tag_t;

    // The whole sequence must fit in one memory
    function automatic bit fits_mem(input int num, input int steps);
        return (num > 0) && (steps > 0) && ((num * steps) <= MEM_DEPTH);
    endfunction

endpackage

// File: rtl/act_mem_sequencer_rd_fifo2.sv
// Two-entry first-word-fall-through FIFO; count feeds the read credit logic.
module rd_fifo2 #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] slot;
    logic              wptr;
    logic              rptr;
    logic              push_en;
    logic              pop_en;

    assign valid   = (count != 2'd0);
    assign dout    = slot[rptr];
    assign pop_en  = pop && valid;
    // A push into a full FIFO is only safe when the head leaves this cycle
    assign push_en = push && ((count != 2'd2) || pop_en);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot  <= '0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push_en) begin
                slot[wptr] <= din;
                wptr       <= ~wptr;
            end
            if (pop_en) begin
                rptr <= ~rptr;
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/act_mem_sequencer.sv
// Activation memory sequencer: fills a dual-port memory in (t,u) order and
// drains it back in reverse timestep order for backprop-through-time.
module act_mem_sequencer
    import lstm_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM      = 53,
    parameter int TIMESTEP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_last_unit,
    output logic              rd_last_step,
    output logic              full,
    output logic              mem_wr_a,
    output logic [ADDR_W-1:0] mem_addr_a,
    output logic [WIDTH-1:0]  mem_i_a,
    output logic [ADDR_W-1:0] mem_addr_b,
    input  logic [WIDTH-1:0]  mem_o_b
);

    generate
        if (!fits_mem(NUM, TIMESTEP)) begin : g_size_check
            $error("act_mem_sequencer: NUM*TIMESTEP exceeds memory depth");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] NUM_A     = ADDR_W'(NUM);
    localparam logic [ADDR_W-1:0] LAST_U    = ADDR_W'(NUM - 1);
    localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'((TIMESTEP - 1) * NUM);

    seq_state_t        state;
    logic [ADDR_W-1:0] wr_u;
    logic [ADDR_W-1:0] wr_base;
    logic [ADDR_W-1:0] rd_u;
    logic [ADDR_W-1:0] rd_base;
    logic              rd_issued_all;
    logic              rd_inflight;
    rd_tag_t           tag_now;
    rd_tag_t           tag_pipe;
    rd_tag_t           head_tag;

    logic              wr_fire;
    logic              wr_last;
    logic              issue;
    logic              pop;
    logic              drain_done;
    logic [2:0]        pending;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic [WIDTH+1:0]  fifo_dout;

    // Write port is driven straight from the handshake
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_last    = wr_fire && (wr_u == LAST_U) && (wr_base == LAST_BASE);
    assign mem_wr_a   = wr_fire;
    assign mem_addr_a = wr_base + wr_u;
    assign mem_i_a    = wr_fire ? wr_data : '0;

    // Tags for the word currently addressed on port B
    assign tag_now.last_unit = (rd_u == LAST_U);
    assign tag_now.last_step = (rd_u == LAST_U) && (rd_base == '0);

    // Credit check: FIFO entries plus the returning word must leave a slot,
    // counting the slot freed by a pop this cycle
    assign pop        = fifo_valid && rd_ready;
    assign pending    = {1'b0, fifo_count} + {2'b00, rd_inflight};
    assign issue      = (state == ST_DRAIN) && !rd_issued_all &&
                        (pending < (pop ? 3'd3 : 3'd2));
    assign head_tag   = rd_tag_t'(fifo_dout[WIDTH +: 2]);
    assign drain_done = pop && head_tag.last_step;

    // Sequencer FSM with fill/drain counters and base-address accumulators
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_FILL;
            wr_ready      <= 1'b1;
            full          <= 1'b0;
            wr_u          <= '0;
            wr_base       <= '0;
            rd_u          <= '0;
            rd_base       <= '0;
            mem_addr_b    <= '0;
            rd_issued_all <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (wr_last) begin
                        wr_u     <= '0;
                        wr_base  <= '0;
                        state    <= ST_FULL;
                        wr_ready <= 1'b0;
                        full     <= 1'b1;
                    end else if (wr_fire) begin
                        if (wr_u == LAST_U) begin
                            wr_u    <= '0;
                            wr_base <= wr_base + NUM_A;
                        end else begin
                            wr_u <= wr_u + 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (rd_start) begin
                        state         <= ST_DRAIN;
                        full          <= 1'b0;
                        rd_u          <= '0;
                        rd_base       <= LAST_BASE;
                        mem_addr_b    <= LAST_BASE;
                        rd_issued_all <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        if (tag_now.last_step) begin
                            rd_issued_all <= 1'b1;
                        end else if (tag_now.last_unit) begin
                            rd_u       <= '0;
                            rd_base    <= rd_base - NUM_A;
                            mem_addr_b <= rd_base - NUM_A;
                        end else begin
                            rd_u       <= rd_u + 1'b1;
                            mem_addr_b <= mem_addr_b + 1'b1;
                        end
                    end
                    if (drain_done) begin
                        state         <= ST_FILL;
                        wr_ready      <= 1'b1;
                        rd_u          <= '0;
                        rd_base       <= '0;
                        rd_issued_all <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_FILL;
                    wr_ready <= 1'b1;
                    full     <= 1'b0;
                end
            endcase
        end
    end

    // Track the read whose data returns on mem_o_b next cycle, with its tags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_inflight <= 1'b0;
            tag_pipe    <= '0;
        end else begin
            rd_inflight <= issue;
            tag_pipe    <= tag_now;
        end
    end

    rd_fifo2 #(.W(WIDTH + 2)) u_rd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_inflight),
        .din   ({tag_pipe, mem_o_b}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign rd_valid     = fifo_valid;
    assign rd_data      = fifo_dout[WIDTH-1:0];
    assign rd_last_unit = fifo_valid && head_tag.last_unit;
    assign rd_last_step = fifo_valid && head_tag.last_step;

endmodule
